uart_rx_fsm: RTL and testbench

UART_RX_FSM -- requirements
Module: uart_rx_fsm

---
 rtl/uart_rx_fsm.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_fsm.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fsm.sv
// UART receive control FSM.
// Works with an external edge/bit counter that it enables through cnt_enable.
// Each bit is sampled three times around its centre and resolved by majority vote.
// The FSM steps only at bit end (edge_cnt == Prescale-1).
// Outputs p_data, data_valid, par_err and stop_err are registered.
// data_valid, par_err and stop_err pulse in the cycle after the stop bit ends.
// dbg_state_o exposes the FSM state: 0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP.
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [5:0]            Prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [3:0]            bit_cnt,
  input  logic [4:0]            edge_cnt,
  output logic                  cnt_enable,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stop_err,
  output logic [2:0]            dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH);

  state_t                state_q, state_d;

  logic [2:0]            samp_q, samp_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_flag_q, par_flag_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  valid_q, valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stop_err_q, stop_err_d;

  logic [5:0]            edge6;
  logic [5:0]            half;
  logic                  bit_end;
  logic                  sampled_bit;
  logic                  start_frame;
  logic                  in_data_range;
  logic                  exp_parity;

  // Shared timing decodes. edge_cnt is widened so Prescale = 32 compares cleanly.
  always_comb begin
    edge6         = {1'b0, edge_cnt};
    half          = {1'b0, Prescale[5:1]};
    bit_end       = cnt_enable && (edge6 == (Prescale - 6'd1));
    sampled_bit   = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) |
                    (samp_q[1] & samp_q[2]);
    start_frame   = (state_q == IDLE) && !rx_in;
    in_data_range = (bit_cnt != 4'd0) && (bit_cnt <= LAST_DATA);
    exp_parity    = (^shift_q) ^ par_typ_q;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic. Every transition after IDLE is taken only at bit end.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (!rx_in) state_d = START;
      START:  if (bit_end) state_d = sampled_bit ? IDLE : DATA;
      DATA:   if (bit_end && (bit_cnt == LAST_DATA))
                state_d = par_en_q ? PARITY : STOP;
      PARITY: if (bit_end) state_d = STOP;
      STOP:   if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs. The counter runs in every state except IDLE.
  always_comb begin
    cnt_enable  = (state_q != IDLE);
    dbg_state_o = state_q;
  end

  // Datapath next values: samples, frame settings, shift register, parity flag, output pulses.
  always_comb begin
    samp_d     = samp_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    shift_d    = shift_q;
    par_flag_d = par_flag_q;
    p_data_d   = p_data_q;
    valid_d    = 1'b0;
    par_err_d  = 1'b0;
    stop_err_d = 1'b0;

    if (cnt_enable) begin
      if (edge6 == (half - 6'd1)) samp_d[0] = rx_in;
      if (edge6 == half)          samp_d[1] = rx_in;
      if (edge6 == (half + 6'd1)) samp_d[2] = rx_in;
    end

    if (start_frame) begin
      par_en_d   = par_en;
      par_typ_d  = par_typ;
      shift_d    = '0;
      par_flag_d = 1'b0;
    end

    if (bit_end) begin
      case (state_q)
        DATA: if (in_data_range) shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
        PARITY: if (sampled_bit != exp_parity) par_flag_d = 1'b1;
        STOP: begin
          stop_err_d = !sampled_bit;
          par_err_d  = par_flag_q;
          valid_d    = sampled_bit && !par_flag_q;
          if (sampled_bit && !par_flag_q) p_data_d = shift_q;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers. Reset mid-frame clears everything, so no pulse escapes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      shift_q    <= '0;
      par_flag_q <= 1'b0;
      p_data_q   <= '0;
      valid_q    <= 1'b0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
    end else begin
      samp_q     <= samp_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      shift_q    <= shift_d;
      par_flag_q <= par_flag_d;
      p_data_q   <= p_data_d;
      valid_q    <= valid_d;
      par_err_q  <= par_err_d;
      stop_err_q <= stop_err_d;
    end
  end

  // Registered result outputs.
  always_comb begin
    p_data     = p_data_q;
    data_valid = valid_q;
    par_err    = par_err_q;
    stop_err   = stop_err_q;
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm.
// Models the external edge/bit counter and drives UART frames on rx_in.
// A scoreboard queue holds each frame's expected result as {data_valid, par_err, stop_err, p_data}.
// Entries are pushed when the frame is driven and popped when the DUT pulses.
module tb_uart_rx_fsm;

  localparam int DW = 8;
  localparam int W  = DW + 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_in;
  logic [5:0]    Prescale;
  logic          par_en;
  logic          par_typ;
  logic [3:0]    bit_cnt  = '0;
  logic [4:0]    edge_cnt = '0;
  logic          cnt_enable;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_err;
  logic          stop_err;
  logic [2:0]    dbg_state;

  int            checks    = 0;
  int            errors    = 0;
  int            pulse_cnt = 0;
  logic [DW-1:0] last_good = '0;
  logic [W-1:0]  exp_q[$];

  uart_rx_fsm #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .Prescale   (Prescale),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .bit_cnt    (bit_cnt),
    .edge_cnt   (edge_cnt),
    .cnt_enable (cnt_enable),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stop_err   (stop_err),
    .dbg_state_o(dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Edge/bit counter: counts while enabled, returns to zero when disabled.
  always @(posedge clk) begin
    if (!cnt_enable) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (int'(edge_cnt) == int'(Prescale) - 1) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + 4'd1;
    end else begin
      edge_cnt <= edge_cnt + 5'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor. Every output pulse must match the oldest pending frame.
  // A pulse lasting two cycles pops an empty queue and fails.
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    if (rst === 1'b1 && (data_valid === 1'b1 || par_err === 1'b1 || stop_err === 1'b1)) begin
      pulse_cnt++;
      got = {data_valid, par_err, stop_err, p_data};
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      check("frame_result", 32'(got), 32'(exp));
    end
  end

  task automatic drive_bit(input logic b, input int p);
    rx_in = b;
    repeat (p) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] data, input int p, input logic pen,
                            input logic ptyp, input logic flip, input logic stop_val);
    logic pbit;
    logic good;
    logic perr;
    Prescale = p[5:0];
    par_en   = pen;
    par_typ  = ptyp;
    pbit = (^data) ^ ptyp ^ flip;
    perr = pen && flip;
    good = stop_val && !perr;
    if (good) last_good = data;
    exp_q.push_back({good, perr, !stop_val, last_good});
    drive_bit(1'b0, p);
    for (int i = 0; i < DW; i++) drive_bit(data[i], p);
    if (pen) drive_bit(pbit, p);
    drive_bit(stop_val, p);
    rx_in = 1'b1;
  endtask

  task automatic wait_pulses(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (pulse_cnt < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, 32'(pulse_cnt), 32'(target));
  endtask

  initial begin
    rst      = 1'b1;
    rx_in    = 1'b1;
    Prescale = 6'd8;
    par_en   = 1'b0;
    par_typ  = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_cnt_enable", 32'(cnt_enable), 32'd0);
    check("rst_p_data",     32'(p_data),     32'd0);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_par_err",    32'(par_err),    32'd0);
    check("rst_stop_err",   32'(stop_err),   32'd0);
    check("rst_state",      32'(dbg_state),  32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Prescale 8, no parity, 0xA5.
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_pulses(1, 20, "a5_pulse");
    repeat (3) @(negedge clk);
    check("a5_p_data_hold", 32'(p_data), 32'hA5);

    // Prescale 16, even parity, 0x3C good, then wrong parity bit.
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_pulses(2, 40, "3c_pulse");
    repeat (2) @(negedge clk);
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_pulses(3, 40, "3c_par_err_pulse");
    repeat (3) @(negedge clk);
    check("par_err_p_data_hold", 32'(p_data), 32'h3C);

    // Prescale 8, 0x55 with stop bit low.
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_pulses(4, 20, "stop_err_pulse");
    check("stop_err_state_idle", 32'(dbg_state), 32'd0);
    check("stop_err_cnt_off",    32'(cnt_enable), 32'd0);
    repeat (3) @(negedge clk);

    // Prescale 16, start glitch of 3 cycles.
    Prescale = 6'd16;
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    check("glitch_cnt_on", 32'(cnt_enable), 32'd1);
    repeat (20) @(negedge clk);
    check("glitch_cnt_off", 32'(cnt_enable), 32'd0);
    check("glitch_state",   32'(dbg_state),  32'd0);
    check("glitch_no_pulse", 32'(pulse_cnt), 32'd4);

    // Prescale 32, odd parity, 0x00 and 0xFF back-to-back.
    send_frame(8'h00, 32, 1'b1, 1'b1, 1'b0, 1'b1);
    send_frame(8'hFF, 32, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_pulses(6, 60, "b2b_pulses");
    repeat (3) @(negedge clk);
    check("b2b_p_data", 32'(p_data), 32'hFF);

    // Reset during data bit 4, then 0x81.
    Prescale = 6'd8;
    par_en   = 1'b0;
    drive_bit(1'b0, 8);
    for (int i = 0; i < 4; i++) drive_bit(1'b1 & (i == 0), 8);
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_abort_cnt_on", 32'(cnt_enable), 32'd1);
    rst = 1'b0;
    rx_in = 1'b1;
    @(negedge clk);
    check("abort_cnt_enable", 32'(cnt_enable), 32'd0);
    check("abort_p_data",     32'(p_data),     32'd0);
    check("abort_pulses",     32'({data_valid, par_err, stop_err}), 32'd0);
    check("abort_state",      32'(dbg_state),  32'd0);
    last_good = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_pulses(7, 20, "post_reset_pulse");
    repeat (3) @(negedge clk);
    check("post_reset_p_data", 32'(p_data), 32'h81);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("pulse_total", 32'(pulse_cnt),    32'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
